// File: rtl/mem_1rw_pkg.sv
// Shared types and constants for the 1RW memory initiator and its bench.
package mem_1rw_pkg;

  localparam int MEM_RD_LAT     = 3;
  localparam int DEF_WORD_SIZE  = 256;
  localparam int DEF_NUM_WORDS  = 128;
  localparam int DEF_WRITE_SIZE = 8;
  localparam int DEF_TAG_W      = 4;
  localparam int DEF_AW         = $clog2(DEF_NUM_WORDS);
  localparam int DEF_MW         = DEF_WORD_SIZE / DEF_WRITE_SIZE;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } init_state_t;

  typedef struct packed {
    logic                     we;
    logic [DEF_AW-1:0]        addr;
    logic [DEF_WORD_SIZE-1:0] data;
    logic [DEF_MW-1:0]        wm;
    logic [DEF_TAG_W-1:0]     tag;
  } req_t;

  typedef struct packed {
    logic [DEF_WORD_SIZE-1:0] data;
    logic [DEF_TAG_W-1:0]     tag;
  } resp_t;

endpackage

// File: rtl/mem_1rw_initiator_if.sv
// Request, response and macro-pin bundle; slave modport is the initiator side.
interface mem_1rw_initiator_if
  import mem_1rw_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int WRITE_SIZE = DEF_WRITE_SIZE,
  parameter int TAG_W      = DEF_TAG_W
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam int MW = WORD_SIZE / WRITE_SIZE;

  logic                 IN_req_valid;
  logic                 OUT_req_ready;
  logic                 IN_req_we;
  logic [AW-1:0]        IN_req_addr;
  logic [WORD_SIZE-1:0] IN_req_data;
  logic [MW-1:0]        IN_req_wm;
  logic [TAG_W-1:0]     IN_req_tag;
  logic                 OUT_resp_valid;
  logic                 IN_resp_ready;
  logic [WORD_SIZE-1:0] OUT_resp_data;
  logic [TAG_W-1:0]     OUT_resp_tag;
  logic                 OUT_mem_nce;
  logic                 OUT_mem_nwe;
  logic [AW-1:0]        OUT_mem_addr;
  logic [WORD_SIZE-1:0] OUT_mem_data;
  logic [MW-1:0]        OUT_mem_wm;
  logic [WORD_SIZE-1:0] IN_mem_data;
  logic                 OUT_init_done;

  modport slave (
    input  IN_req_valid, IN_req_we, IN_req_addr, IN_req_data, IN_req_wm, IN_req_tag,
    input  IN_resp_ready, IN_mem_data,
    output OUT_req_ready, OUT_resp_valid, OUT_resp_data, OUT_resp_tag,
    output OUT_mem_nce, OUT_mem_nwe, OUT_mem_addr, OUT_mem_data, OUT_mem_wm, OUT_init_done
  );

  modport master (
    output IN_req_valid, IN_req_we, IN_req_addr, IN_req_data, IN_req_wm, IN_req_tag,
    output IN_resp_ready, IN_mem_data,
    input  OUT_req_ready, OUT_resp_valid, OUT_resp_data, OUT_resp_tag,
    input  OUT_mem_nce, OUT_mem_nwe, OUT_mem_addr, OUT_mem_data, OUT_mem_wm, OUT_init_done
  );

endinterface

// File: rtl/mem_1rw_resp_fifo.sv
// Read-response FIFO; output word is held while the head is not popped.
module mem_1rw_resp_fifo #(
  parameter int RESP_DEPTH = 4,
  parameter int WIDTH      = 260
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             not_empty
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [WIDTH-1:0] mem [RESP_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout      = mem[rd_ptr];
  assign not_empty = (count != '0);

endmodule

// File: rtl/mem_1rw_initiator.sv
// Credit-flowed initiator for a 1RW SRAM macro with registered pins and in-order reads.
// Define MEM_1RW_INIT_CLEAR_EN to zero the whole macro after every reset.
module mem_1rw_initiator
  import mem_1rw_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int WRITE_SIZE = DEF_WRITE_SIZE,
  parameter int TAG_W      = DEF_TAG_W,
  parameter int RESP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_1rw_initiator_if.slave bus
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam int MW = WORD_SIZE / WRITE_SIZE;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int FW = WORD_SIZE + TAG_W;

  logic                 init_done;
  logic [CW-1:0]        credits;
  logic                 acc;
  logic                 acc_rd;
  logic                 pop;
  logic                 fifo_vld;
  logic [FW-1:0]        fifo_dout;
  logic                 vld_p0, vld_p1, vld_p2;
  logic [TAG_W-1:0]     tag_p0, tag_p1, tag_p2;
  logic                 nce_nxt, nwe_nxt;
  logic [AW-1:0]        addr_nxt;
  logic [WORD_SIZE-1:0] data_nxt;
  logic [MW-1:0]        wm_nxt;

  // Credits cover both reads in the pipe and queued responses, so a push can never hit a full FIFO.
  assign bus.OUT_req_ready = init_done && (credits != '0);
  assign acc               = bus.IN_req_valid && bus.OUT_req_ready;
  assign acc_rd            = acc && !bus.IN_req_we;
  assign pop               = fifo_vld && bus.IN_resp_ready;
  assign bus.OUT_init_done = init_done;

`ifdef MEM_1RW_INIT_CLEAR_EN
  init_state_t   state, state_nxt;
  logic [AW-1:0] init_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_addr <= init_addr + AW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    nce_nxt   = ~acc;
    nwe_nxt   = ~(acc & bus.IN_req_we);
    addr_nxt  = bus.IN_req_addr;
    data_nxt  = bus.IN_req_data;
    wm_nxt    = (acc && bus.IN_req_we) ? bus.IN_req_wm : '0;
    if (state == ST_INIT) begin
      nce_nxt  = 1'b0;
      nwe_nxt  = 1'b0;
      addr_nxt = init_addr;
      data_nxt = '0;
      wm_nxt   = '1;
      if (init_addr == AW'(NUM_WORDS - 1)) state_nxt = ST_IDLE;
    end
  end

  assign init_done = (state == ST_IDLE);
`else
  always_ff @(posedge clk) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  always_comb begin
    nce_nxt  = ~acc;
    nwe_nxt  = ~(acc & bus.IN_req_we);
    addr_nxt = bus.IN_req_addr;
    data_nxt = bus.IN_req_data;
    wm_nxt   = (acc && bus.IN_req_we) ? bus.IN_req_wm : '0;
  end
`endif

  // p0: macro pins launched the cycle after accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.OUT_mem_nce  <= 1'b1;
      bus.OUT_mem_nwe  <= 1'b1;
      bus.OUT_mem_addr <= '0;
      bus.OUT_mem_data <= '0;
      bus.OUT_mem_wm   <= '0;
    end else begin
      bus.OUT_mem_nce  <= nce_nxt;
      bus.OUT_mem_nwe  <= nwe_nxt;
      bus.OUT_mem_addr <= addr_nxt;
      bus.OUT_mem_data <= data_nxt;
      bus.OUT_mem_wm   <= wm_nxt;
    end
  end

  // p0..p2: read tracking; p2 lines up with the cycle the macro presents its data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= acc_rd;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    tag_p0 <= bus.IN_req_tag;
    tag_p1 <= tag_p0;
    tag_p2 <= tag_p1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits <= CW'(RESP_DEPTH);
    end else begin
      case ({acc_rd, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  mem_1rw_resp_fifo #(
    .RESP_DEPTH (RESP_DEPTH),
    .WIDTH      (FW)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p2),
    .din       ({bus.IN_mem_data, tag_p2}),
    .pop       (pop),
    .dout      (fifo_dout),
    .not_empty (fifo_vld)
  );

  assign bus.OUT_resp_valid = fifo_vld;
  assign bus.OUT_resp_data  = fifo_dout[FW-1:TAG_W];
  assign bus.OUT_resp_tag   = fifo_dout[TAG_W-1:0];

endmodule

// File: tb/tb_mem_1rw_initiator.sv
// Directed bench for mem_1rw_initiator with a behavioural 1RW macro attached to the pins.
module tb_mem_1rw_initiator;
  import mem_1rw_pkg::*;

  localparam int WS    = DEF_WORD_SIZE;
  localparam int NW    = DEF_NUM_WORDS;
  localparam int GS    = DEF_WRITE_SIZE;
  localparam int TW    = DEF_TAG_W;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(NW);
  localparam int MW    = WS / GS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mem_1rw_initiator_if #(.WORD_SIZE(WS), .NUM_WORDS(NW), .WRITE_SIZE(GS), .TAG_W(TW)) bus ();

  mem_1rw_initiator #(
    .WORD_SIZE (WS),
    .NUM_WORDS (NW),
    .WRITE_SIZE(GS),
    .TAG_W     (TW),
    .RESP_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [WS-1:0] mac_mem [NW];
  logic [WS-1:0] ref_mem [NW];
  logic          rd_lat = 1'b0;
  logic [AW-1:0] rd_addr;
  resp_t         got_q[$];
  resp_t         exp_q[$];

  function automatic logic [WS-1:0] rep(input logic [7:0] b);
    rep = {(WS/8){b}};
  endfunction

  function automatic logic [WS-1:0] merge(input logic [WS-1:0] old, input logic [WS-1:0] d,
                                          input logic [MW-1:0] m);
    merge = old;
    for (int i = 0; i < MW; i++)
      if (m[i]) merge[i*GS +: GS] = d[i*GS +: GS];
  endfunction

  // Macro: latch pins at the edge ending t+1, read executes at the next edge, data held through t+3.
  always @(posedge clk) begin
    if (!bus.OUT_mem_nce && !bus.OUT_mem_nwe)
      mac_mem[bus.OUT_mem_addr] <= merge(mac_mem[bus.OUT_mem_addr], bus.OUT_mem_data, bus.OUT_mem_wm);
    rd_lat  <= !bus.OUT_mem_nce && bus.OUT_mem_nwe;
    rd_addr <= bus.OUT_mem_addr;
    if (rd_lat) bus.IN_mem_data <= mac_mem[rd_addr];
  end

  always @(negedge clk) begin
    if (rst_n && bus.OUT_resp_valid && bus.IN_resp_ready)
      got_q.push_back('{data: bus.OUT_resp_data, tag: bus.OUT_resp_tag});
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [WS-1:0] d,
                       input logic [MW-1:0] m, input logic [TW-1:0] t);
    int n = 0;
    bus.IN_req_valid = 1'b1;
    bus.IN_req_we    = we;
    bus.IN_req_addr  = a;
    bus.IN_req_data  = d;
    bus.IN_req_wm    = m;
    bus.IN_req_tag   = t;
    while (!bus.OUT_req_ready && n < 50) begin
      step();
      n++;
    end
    if (!bus.OUT_req_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: req_ready=0 after 50 cycles, required 1");
      bus.IN_req_valid = 1'b0;
    end else begin
      if (we) ref_mem[a] = merge(ref_mem[a], d, m);
      else    exp_q.push_back('{data: ref_mem[a], tag: t});
      step();
    end
  endtask

  task automatic wait_resp(input int n, input int bound);
    int k = 0;
    while (got_q.size() < n && k < bound) begin
      step();
      k++;
    end
  endtask

  task automatic wait_init();
    int k = 0;
    while (!bus.OUT_init_done && k < NW + 20) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({bus.OUT_mem_nce, bus.OUT_mem_nwe, bus.OUT_resp_valid, bus.OUT_req_ready, bus.OUT_init_done} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_ctrl: {nce,nwe,resp_valid,req_ready,init_done}=%b required 11000",
               {bus.OUT_mem_nce, bus.OUT_mem_nwe, bus.OUT_resp_valid, bus.OUT_req_ready, bus.OUT_init_done});
    end
    checks++;
    if ({bus.OUT_mem_addr, bus.OUT_mem_data, bus.OUT_mem_wm} !== '0) begin
      failures++;
      $display("FAIL reset_pins: addr=%h wm=%h data=%h required all zero",
               bus.OUT_mem_addr, bus.OUT_mem_wm, bus.OUT_mem_data);
    end
    rst_n = 1'b1;
`ifdef MEM_1RW_INIT_CLEAR_EN
    begin
      int n = 0;
      int k = 0;
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;
      while (!bus.OUT_init_done && k < NW + 20) begin
        step();
        k++;
        if (!bus.OUT_mem_nce && !bus.OUT_mem_nwe && bus.OUT_mem_wm == '1 && bus.OUT_mem_data == '0) n++;
      end
      checks++;
      if (n !== NW) begin
        failures++;
        $display("FAIL init_sweep: clear writes=%0d required %0d", n, NW);
      end
      bus.IN_resp_ready = 1'b1;
      got_q.delete();
      issue(1'b0, AW'(100), '0, '0, 4'd6);
      bus.IN_req_valid = 1'b0;
      wait_resp(1, 20);
      checks++;
      if (got_q.size() != 1 || got_q[0].data !== '0) begin
        failures++;
        $display("FAIL init_cleared_read: responses=%0d data=%h required one response of 0",
                 got_q.size(), (got_q.size() > 0) ? got_q[0].data : '1);
      end
      bus.IN_resp_ready = 1'b0;
    end
`else
    step();
    checks++;
    if ({bus.OUT_init_done, bus.OUT_req_ready} !== 2'b11) begin
      failures++;
      $display("FAIL init_done: {init_done,req_ready}=%b required 11", {bus.OUT_init_done, bus.OUT_req_ready});
    end
`endif
  endtask

  task automatic test_read_latency();
    int lat = 1;
    bus.IN_resp_ready = 1'b1;
    issue(1'b1, AW'(5), rep(8'hA5), '1, 4'd0);
    checks++;
    if ({bus.OUT_mem_nce, bus.OUT_mem_nwe} !== 2'b00 || bus.OUT_mem_addr !== AW'(5) ||
        bus.OUT_mem_wm !== '1 || bus.OUT_mem_data !== rep(8'hA5)) begin
      failures++;
      $display("FAIL write_pins: nce=%b nwe=%b addr=%0d wm=%h required 0 0 5 ffffffff",
               bus.OUT_mem_nce, bus.OUT_mem_nwe, bus.OUT_mem_addr, bus.OUT_mem_wm);
    end
    issue(1'b0, AW'(5), '0, '0, 4'd3);
    bus.IN_req_valid = 1'b0;
    checks++;
    if ({bus.OUT_mem_nce, bus.OUT_mem_nwe} !== 2'b01 || bus.OUT_mem_addr !== AW'(5) || bus.OUT_mem_wm !== '0) begin
      failures++;
      $display("FAIL read_pins: nce=%b nwe=%b addr=%0d wm=%h required 0 1 5 0",
               bus.OUT_mem_nce, bus.OUT_mem_nwe, bus.OUT_mem_addr, bus.OUT_mem_wm);
    end
    while (!bus.OUT_resp_valid && lat < 10) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL read_latency: got %0d cycles required 4", lat);
    end
    checks++;
    if (bus.OUT_resp_data !== rep(8'hA5) || bus.OUT_resp_tag !== 4'd3) begin
      failures++;
      $display("FAIL read_data: data=%h tag=%0d required a5.. tag 3", bus.OUT_resp_data, bus.OUT_resp_tag);
    end
    step();
  endtask

  task automatic test_write_mask();
    got_q.delete();
    bus.IN_resp_ready = 1'b1;
    issue(1'b1, AW'(7), rep(8'h3C), '1, 4'd0);
    issue(1'b1, AW'(7), WS'(8'hFF), MW'(1), 4'd0);
    issue(1'b0, AW'(7), '0, '0, 4'd9);
    bus.IN_req_valid = 1'b0;
    step();
    checks++;
    if ({bus.OUT_mem_nce, bus.OUT_mem_nwe} !== 2'b11) begin
      failures++;
      $display("FAIL idle_pins: nce=%b nwe=%b required 1 1", bus.OUT_mem_nce, bus.OUT_mem_nwe);
    end
    wait_resp(1, 20);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== '{data: {{31{8'h3C}}, 8'hFF}, tag: 4'd9}) begin
      failures++;
      $display("FAIL write_mask: responses=%0d data=%h required 3c..3cff tag 9",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : '0);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic [WS-1:0] hold_d;
    logic [TW-1:0] hold_t;
    bus.IN_resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) issue(1'b1, AW'(10 + i), rep(8'(8'h11 * (i + 1))), '1, 4'd0);
    bus.IN_req_valid  = 1'b0;
    bus.IN_resp_ready = 1'b0;
    step();
    got_q.delete();
    for (int i = 0; i < 6; i++) begin
      bus.IN_req_valid = 1'b1;
      bus.IN_req_we    = 1'b0;
      bus.IN_req_addr  = AW'(10 + i);
      bus.IN_req_tag   = TW'(i);
      if (bus.OUT_req_ready) acc++;
      step();
    end
    bus.IN_req_valid = 1'b0;
    checks++;
    if (acc !== 4) begin
      failures++;
      $display("FAIL bp_accepts: accepted %0d required 4", acc);
    end
    step();
    step();
    checks++;
    if (bus.OUT_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_low: req_ready=%b required 0", bus.OUT_req_ready);
    end
    hold_d = bus.OUT_resp_data;
    hold_t = bus.OUT_resp_tag;
    step();
    step();
    step();
    checks++;
    if (!bus.OUT_resp_valid || bus.OUT_resp_data !== rep(8'h11) || bus.OUT_resp_tag !== 4'd0 ||
        bus.OUT_resp_data !== hold_d || bus.OUT_resp_tag !== hold_t) begin
      failures++;
      $display("FAIL bp_hold: valid=%b tag=%0d data=%h required valid, tag 0, 11.. held",
               bus.OUT_resp_valid, bus.OUT_resp_tag, bus.OUT_resp_data);
    end
    bus.IN_resp_ready = 1'b1;
    wait_resp(4, 20);
    step();
    step();
    checks++;
    if (got_q.size() != 4) begin
      failures++;
      $display("FAIL bp_count: responses %0d required 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].tag !== TW'(k) || got_q[k].data !== rep(8'(8'h11 * (k + 1)))) begin
        failures++;
        $display("FAIL bp_order[%0d]: tag=%0d data=%h required tag %0d", k, got_q[k].tag, got_q[k].data, k);
      end
    end
    checks++;
    if (bus.OUT_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_back: req_ready=%b required 1", bus.OUT_req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    bus.IN_resp_ready = 1'b1;
    got_q.delete();
    issue(1'b0, AW'(20), '0, '0, 4'd1);
    issue(1'b0, AW'(21), '0, '0, 4'd2);
    bus.IN_req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`ifdef MEM_1RW_INIT_CLEAR_EN
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
`endif
    wait_init();
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (got_q.size() != 0 || bus.OUT_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_flush: responses=%0d resp_valid=%b required 0 0", got_q.size(), bus.OUT_resp_valid);
    end
    bus.IN_resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.IN_req_valid = 1'b1;
      bus.IN_req_we    = 1'b0;
      bus.IN_req_addr  = AW'(30 + i);
      bus.IN_req_tag   = TW'(i);
      if (bus.OUT_req_ready) acc++;
      step();
    end
    bus.IN_req_valid = 1'b0;
    checks++;
    if (acc !== DEPTH) begin
      failures++;
      $display("FAIL rst_mid_credits: accepted %0d required %0d", acc, DEPTH);
    end
    bus.IN_resp_ready = 1'b1;
    wait_resp(4, 20);
    step();
    step();
  endtask

  task automatic test_stream();
    logic [23:0] we_pat = 24'b1010_0110_1100_1001_0110_1101;
    bus.IN_resp_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 24; i++)
      issue(we_pat[i], AW'(48 + (i % 3)), {(WS/32){32'(i) * 32'h0101_0101 + 32'h1000}},
            MW'(32'hF0F0_F0F0 ^ (32'h1 << i)), TW'(i));
    bus.IN_req_valid = 1'b0;
    wait_resp(exp_q.size(), 60);
    step();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL stream_count: responses %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL stream[%0d]: tag=%0d data=%h required tag=%0d data=%h",
                 k, got_q[k].tag, got_q[k].data, exp_q[k].tag, exp_q[k].data);
      end
    end
  endtask

  initial begin
    bus.IN_req_valid  = 1'b0;
    bus.IN_req_we     = 1'b0;
    bus.IN_req_addr   = '0;
    bus.IN_req_data   = '0;
    bus.IN_req_wm     = '0;
    bus.IN_req_tag    = '0;
    bus.IN_resp_ready = 1'b0;
    for (int i = 0; i < NW; i++) begin
      mac_mem[i] <= rep(8'hEE);
      ref_mem[i] = rep(8'hEE);
    end
    test_reset();
    test_read_latency();
    test_write_mask();
    test_backpressure();
    test_reset_mid();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
